fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 17 +
 rtl/fetch_ctrl_redir_buf.sv | 25 ++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants and state type for the instruction fetch controller
// ST_DRAIN exists only when FETCH_EXC_EN is defined.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_HOLD
`ifdef FETCH_EXC_EN
    , ST_DRAIN
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_redir_buf.sv
// rtl/fetch_ctrl_redir_buf.sv - one-entry pending redirect buffer (valid + target)
// Clear has priority over set, so a redirect consumed on the same edge never lingers.
module redir_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [31:0] set_target,
  input  logic        clr,
  output logic        valid,
  output logic [31:0] target
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (clr) begin
      valid  <= 1'b0;
    end else if (set) begin
      valid  <= 1'b1;
      target <= set_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller with delay-slot redirect and output skid
// Optional exception/eret flush with DRAIN state under macro FETCH_EXC_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_ds,
`ifdef FETCH_EXC_EN
  input  logic        exc_valid,
  input  logic        eret_valid,
  input  logic [31:0] epc,
`endif
  input  logic        id_ready
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  skid_pc, skid_instr;
  logic         skid_ds;
  logic         buf_valid, buf_clr, redir_hit;
  logic [31:0]  buf_target, next_pc;
  logic         ack_take, out_free, consume;

  assign ack_take  = (state == ST_FETCH) && imem_ack;
  assign out_free  = !if_valid || id_ready;
  assign consume   = if_valid && id_ready;
  assign redir_hit = redir_valid || buf_valid;
  // A live redirect is newer than anything buffered, so it takes precedence.
  assign next_pc   = redir_valid ? redir_target :
                     buf_valid   ? buf_target   : imem_addr + 32'd4;

`ifdef FETCH_EXC_EN
  logic        flush;
  logic [31:0] flush_pc;
  assign flush    = exc_valid || eret_valid;
  assign flush_pc = exc_valid ? EXC_VECTOR : epc;
  assign buf_clr  = ack_take || flush;
`else
  assign buf_clr  = ack_take;
`endif

  redir_buf u_redir_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .set        (redir_valid),
    .set_target (redir_target),
    .clr        (buf_clr),
    .valid      (buf_valid),
    .target     (buf_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      if_ds      <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      skid_ds    <= 1'b0;
    end else begin
      if (consume) if_valid <= 1'b0;
      case (state)
        ST_BOOT: begin
          state     <= ST_FETCH;
          imem_req  <= 1'b1;
          imem_addr <= pc;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            pc        <= next_pc;
            imem_addr <= next_pc;
            if (out_free) begin
              if_valid <= 1'b1;
              if_pc    <= imem_addr;
              if_instr <= imem_rdata;
              if_ds    <= redir_hit;
            end else begin
              // Word arrived while ID is stalled: park it and stop requesting.
              skid_pc    <= imem_addr;
              skid_instr <= imem_rdata;
              skid_ds    <= redir_hit;
              state      <= ST_HOLD;
              imem_req   <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (consume) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
            if_ds    <= skid_ds;
            state    <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
`ifdef FETCH_EXC_EN
        ST_DRAIN: begin
          if (imem_ack) begin
            state     <= ST_FETCH;
            imem_addr <= pc;
          end
        end
`endif
        default: state <= ST_BOOT;
      endcase
`ifdef FETCH_EXC_EN
      if (flush) begin
        if_valid <= 1'b0;
        pc       <= flush_pc;
        imem_req <= 1'b1;
        // An unacked request must complete at its original address before refetch.
        if (imem_req && !imem_ack) begin
          state     <= ST_DRAIN;
          imem_addr <= imem_addr;
        end else begin
          state     <= ST_FETCH;
          imem_addr <= flush_pc;
        end
      end
`endif
    end
  end

endmodule
